regfile_mp: RTL and testbench

- Parametrised multi-port general-purpose register file; the next generation of the CPU's GPR array.
- Provides NUM_RD combinational read ports and two write ports:
  - port A: ALU/load writeback, with overflow cancel.
  - port B: long-latency writeback (mul/div unit).
- Adds a per-register busy scoreboard so decode can stall on pending long-latency results.
- Sits between decode (reads, reservations) and writeback.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_mp_if.sv | 33 +++
 rtl/regfile_scoreboard.sv | 35 +++
 rtl/regfile_mp.sv | 92 +++++++++
 tb/tb_regfile_mp.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port GPR file.
// The struct is sized for the largest supported DW and register count.
package regfile_pkg;

  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 32;
  localparam int DW_MAX    = 64;
  localparam int AW_MAX    = 16;

  typedef struct packed {
    logic              en;
    logic [AW_MAX-1:0] addr;
    logic [DW_MAX-1:0] data;
  } wr_req_t;

  function automatic logic is_zero_reg(input logic [AW_MAX-1:0] addr, input logic r0_zero);
    return r0_zero && (addr == '0);
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback bus of the GPR file: read ports, two write ports, reservations.
interface regfile_mp_if #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*DW-1:0] rd_data;
  logic [NUM_RD-1:0]    rd_busy;
  logic                 wa_en;
  logic [AW-1:0]        wa_addr;
  logic [DW-1:0]        wa_data;
  logic                 wa_cancel;
  logic                 wb_en;
  logic [AW-1:0]        wb_addr;
  logic [DW-1:0]        wb_data;
  logic                 rsv_en;
  logic [AW-1:0]        rsv_addr;
  logic                 flush;
  logic                 busy_any;

  modport master (
    output rd_addr, wa_en, wa_addr, wa_data, wa_cancel,
           wb_en, wb_addr, wb_data, rsv_en, rsv_addr, flush,
    input  rd_data, rd_busy, busy_any
  );

  modport slave (
    input  rd_addr, wa_en, wa_addr, wa_data, wa_cancel,
           wb_en, wb_addr, wb_data, rsv_en, rsv_addr, flush,
    output rd_data, rd_busy, busy_any
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy vector: flush, then port B clear, then reservation set,
// so a reservation always survives a same-edge flush or clear.
module regfile_scoreboard #(
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  input  logic             flush,
  output logic [DEPTH-1:0] busy,
  output logic             busy_any
);

  logic [DEPTH-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (flush)  busy_d = '0;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy     = busy_q;
  assign busy_any = |busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file with long-latency busy scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards committing writes to same-cycle reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int DW      = DW_DEF,
  parameter  int DEPTH   = DEPTH_DEF,
  parameter  int NUM_RD  = 2,
  parameter  int R0_ZERO = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);

  localparam logic R0Z = (R0_ZERO != 0);

  wr_req_t          wa_req, wb_req;
  logic             rsv_ok;
  logic [DW-1:0]    regs_q [DEPTH];
  logic [DW-1:0]    regs_d [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             busy_any;

  // Requests are qualified once here; everything downstream trusts .en.
  always_comb begin
    wa_req.en   = bus.wa_en && !bus.wa_cancel && !is_zero_reg(AW_MAX'(bus.wa_addr), R0Z);
    wa_req.addr = AW_MAX'(bus.wa_addr);
    wa_req.data = DW_MAX'(bus.wa_data);
    wb_req.en   = bus.wb_en && !is_zero_reg(AW_MAX'(bus.wb_addr), R0Z);
    wb_req.addr = AW_MAX'(bus.wb_addr);
    wb_req.data = DW_MAX'(bus.wb_data);
    rsv_ok      = bus.rsv_en && !is_zero_reg(AW_MAX'(bus.rsv_addr), R0Z);
  end

  logic unused_req;
  assign unused_req = ^{wa_req, wb_req};

  // Port A is applied last so it wins a same-address collision.
  always_comb begin
    regs_d = regs_q;
    if (wb_req.en) regs_d[wb_req.addr[AW-1:0]] = wb_req.data[DW-1:0];
    if (wa_req.en) regs_d[wa_req.addr[AW-1:0]] = wa_req.data[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  regfile_scoreboard #(.DEPTH(DEPTH)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (rsv_ok),
    .set_addr (bus.rsv_addr),
    .clr_en   (wb_req.en),
    .clr_addr (wb_req.addr[AW-1:0]),
    .flush    (bus.flush),
    .busy     (busy),
    .busy_any (busy_any)
  );

  assign bus.busy_any = busy_any;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic [DW-1:0] rdat;
    logic          rbusy;

    assign a = bus.rd_addr[i*AW +: AW];

    always_comb begin
      rdat  = regs_q[a];
      rbusy = busy[a];
`ifdef REGFILE_BYPASS_EN
      if (wa_req.en && wa_req.addr[AW-1:0] == a)      rdat = wa_req.data[DW-1:0];
      else if (wb_req.en && wb_req.addr[AW-1:0] == a) rdat = wb_req.data[DW-1:0];
      if (wb_req.en && wb_req.addr[AW-1:0] == a)      rbusy = 1'b0;
`endif
      // Forwarding must not leak input data while the array is held in reset.
      if (!rst_n) begin
        rdat  = '0;
        rbusy = 1'b0;
      end
    end

    assign bus.rd_data[i*DW +: DW] = rdat;
    assign bus.rd_busy[i]          = rbusy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised + directed bench for regfile_mp against an array/bit-set model.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.DW(32), .AW(5), .NUM_RD(2)) bus0 ();
  regfile_mp_if #(.DW(64), .AW(4), .NUM_RD(4)) bus1 ();

  regfile_mp #(.DW(32), .DEPTH(32), .NUM_RD(2), .R0_ZERO(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  regfile_mp #(.DW(64), .DEPTH(16), .NUM_RD(4), .R0_ZERO(0)) dut64 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit a_commit();
    return bus0.wa_en && !bus0.wa_cancel && bus0.wa_addr != 5'd0;
  endfunction

  function automatic bit b_commit();
    return bus0.wb_en && bus0.wb_addr != 5'd0;
  endfunction

  // Register 0 is hard zero; otherwise stored value unless a forwarded write applies.
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'd0 : m_regs[a];
    if (BYP) begin
      if (a_commit() && bus0.wa_addr == a)      v = bus0.wa_data;
      else if (b_commit() && bus0.wb_addr == a) v = bus0.wb_data;
    end
    return v;
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (BYP && b_commit() && bus0.wb_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_busy = '0;
  endtask

  task automatic model_update();
    logic [31:0] nb;
    if (!rst_n) begin
      model_reset();
      return;
    end
    nb = m_busy;
    if (bus0.flush) nb = '0;
    if (b_commit()) nb[bus0.wb_addr] = 1'b0;
    if (bus0.rsv_en && bus0.rsv_addr != 5'd0) nb[bus0.rsv_addr] = 1'b1;
    if (b_commit()) m_regs[bus0.wb_addr] = bus0.wb_data;
    if (a_commit()) m_regs[bus0.wa_addr] = bus0.wa_data;
    m_busy = nb;
  endtask

  task automatic idle();
    bus0.wa_en = 0; bus0.wa_addr = 0; bus0.wa_data = 0; bus0.wa_cancel = 0;
    bus0.wb_en = 0; bus0.wb_addr = 0; bus0.wb_data = 0;
    bus0.rsv_en = 0; bus0.rsv_addr = 0; bus0.flush = 0;
  endtask

  task automatic idle1();
    bus1.wa_en = 0; bus1.wa_addr = 0; bus1.wa_data = 0; bus1.wa_cancel = 0;
    bus1.wb_en = 0; bus1.wb_addr = 0; bus1.wb_data = 0;
    bus1.rsv_en = 0; bus1.rsv_addr = 0; bus1.flush = 0;
    bus1.rd_addr = '0;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    bus0.rd_addr = {a1, a0};
  endtask

  task automatic check_reads();
    for (int i = 0; i < 2; i++) begin
      logic [4:0] a;
      a = bus0.rd_addr[i*5 +: 5];
      chk($sformatf("rd_data%0d[r%0d]", i, a), 64'(bus0.rd_data[i*32 +: 32]), 64'(exp_rd(a)));
      chk($sformatf("rd_busy%0d[r%0d]", i, a), 64'(bus0.rd_busy[i]), 64'(exp_busy(a)));
    end
    chk("busy_any", 64'(bus0.busy_any), 64'(|m_busy));
  endtask

  // Inputs are driven just after negedge; the model steps at the posedge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic cyc();
    #1 check_reads();
    tick();
  endtask

  initial begin
    model_reset();
    idle(); idle1(); set_rd(5'd0, 5'd1);
    repeat (2) @(negedge clk);
    #1 chk("rst_rd_data", 64'(bus0.rd_data), 64'd0);
    chk("rst_busy_any", 64'(bus0.busy_any), 64'd0);
    chk("rst_rd_busy", 64'(bus0.rd_busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Asynchronous reset mid-run clears data immediately.
    bus0.wa_en = 1; bus0.wa_addr = 5; bus0.wa_data = 32'hDEADBEEF; set_rd(5'd5, 5'd0);
    cyc(); idle();
    #1 chk("r5_written", 64'(bus0.rd_data[31:0]), 64'hDEADBEEF);
    #1 rst_n = 1'b0; model_reset();
    #1 chk("rst_async_data", 64'(bus0.rd_data[31:0]), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rst_release_r5", 64'(bus0.rd_data[31:0]), 64'd0);
    chk("rst_release_busy", 64'(bus0.busy_any), 64'd0);
    @(negedge clk);

    // Port A cancel, normal write, write to r0.
    bus0.wa_en = 1; bus0.wa_addr = 3; bus0.wa_data = 32'h1234; bus0.wa_cancel = 1; set_rd(5'd3, 5'd0);
    cyc(); idle();
    #1 chk("cancel_r3", 64'(bus0.rd_data[31:0]), 64'd0);
    bus0.wa_en = 1; bus0.wa_addr = 3; bus0.wa_data = 32'h1234;
    tick(); idle();
    #1 chk("wa_r3", 64'(bus0.rd_data[31:0]), 64'h1234);
    bus0.wa_en = 1; bus0.wa_addr = 0; bus0.wa_data = 32'hFFFF; set_rd(5'd0, 5'd3);
    cyc(); idle();
    #1 chk("r0_zero", 64'(bus0.rd_data[31:0]), 64'd0);

    // Reservation then long-latency writeback.
    bus0.rsv_en = 1; bus0.rsv_addr = 7; set_rd(5'd7, 5'd0);
    cyc(); idle();
    repeat (5) cyc();
    #1 chk("rsv_r7_busy", 64'(bus0.rd_busy[0]), 64'd1);
    chk("rsv_busy_any", 64'(bus0.busy_any), 64'd1);
    bus0.wb_en = 1; bus0.wb_addr = 7; bus0.wb_data = 32'hA5A5A5A5;
    cyc(); idle();
    #1 chk("wb_r7_data", 64'(bus0.rd_data[31:0]), 64'hA5A5A5A5);
    chk("wb_r7_busy", 64'(bus0.rd_busy[0]), 64'd0);

    // Same-cycle A/B collision on a busy register.
    bus0.rsv_en = 1; bus0.rsv_addr = 9; set_rd(5'd9, 5'd7);
    cyc(); idle();
    bus0.wa_en = 1; bus0.wa_addr = 9; bus0.wa_data = 32'h11;
    bus0.wb_en = 1; bus0.wb_addr = 9; bus0.wb_data = 32'h22;
    cyc(); idle();
    #1 chk("coll_r9_data", 64'(bus0.rd_data[31:0]), 64'h11);
    chk("coll_r9_busy", 64'(bus0.rd_busy[0]), 64'd0);

    // Reservation beats a same-cycle port B clear.
    bus0.rsv_en = 1; bus0.rsv_addr = 4; set_rd(5'd4, 5'd9);
    cyc(); idle();
    bus0.rsv_en = 1; bus0.rsv_addr = 4; bus0.wb_en = 1; bus0.wb_addr = 4; bus0.wb_data = 32'h77;
    cyc(); idle();
    #1 chk("rsv_vs_clr_r4", 64'(bus0.rd_busy[0]), 64'd1);

    // Flush with reservation leaves exactly {r2}.
    bus0.rsv_en = 1; bus0.rsv_addr = 6; set_rd(5'd6, 5'd2);
    cyc(); idle();
    bus0.flush = 1; bus0.rsv_en = 1; bus0.rsv_addr = 2;
    cyc(); idle();
    for (int r = 0; r < 32; r++) begin
      set_rd(5'(r), 5'd2);
      #1 chk($sformatf("flush_set_r%0d", r), 64'(bus0.rd_busy[0]), 64'(r == 2));
      tick();
    end

    // Forwarding: old value this cycle without bypass, new value either way next cycle.
    bus0.wa_en = 1; bus0.wa_addr = 8; bus0.wa_data = 32'h10; set_rd(5'd8, 5'd0);
    tick();
    bus0.wa_data = 32'h55;
    #1 chk("bypass_same_cycle", 64'(bus0.rd_data[31:0]), BYP ? 64'h55 : 64'h10);
    check_reads();
    tick(); idle();
    #1 chk("bypass_next_cycle", 64'(bus0.rd_data[31:0]), 64'h55);

    // Wide build with R0 as a normal register.
    bus1.wa_en = 1; bus1.wa_addr = 0; bus1.wa_data = 64'hCAFE;
    tick(); idle1();
    #1 for (int p = 0; p < 4; p++)
      chk($sformatf("wide_r0_port%0d", p), bus1.rd_data[p*64 +: 64], 64'hCAFE);

    // Random traffic concentrated on a few registers to force collisions.
    for (int n = 0; n < 400; n++) begin
      bus0.wa_en     = ($urandom_range(0, 1) == 0);
      bus0.wa_cancel = ($urandom_range(0, 3) == 0);
      bus0.wa_addr   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      bus0.wa_data   = $urandom;
      bus0.wb_en     = ($urandom_range(0, 4) < 2);
      bus0.wb_addr   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      bus0.wb_data   = $urandom;
      bus0.rsv_en    = ($urandom_range(0, 9) < 3);
      bus0.rsv_addr  = 5'($urandom_range(0, 7));
      bus0.flush     = ($urandom_range(0, 19) == 0);
      set_rd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      cyc();
    end
    idle();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
